// File: rtl/memory_access.sv
// Memory-access pipeline stage: drives a request/ack data bus for loads and
// stores, stalls the upstream pipeline while an access is in flight, resolves
// branches, and owns the MEM/WB pipeline register.
module memory_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MEM_bpc,
  input  logic [31:0] MEM_alu_out,
  input  logic [31:0] MEM_rd2,
  input  logic [1:0]  MEM_ctlwb,
  input  logic [2:0]  MEM_ctlm,
  input  logic        MEM_alu_zero,
  input  logic [4:0]  MEM_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        MEM_pcsrc,
  output logic [31:0] MEM_target,
  output logic        MEM_stall,
  output logic [1:0]  WB_ctlwb,
  output logic [31:0] WB_read_data,
  output logic [31:0] WB_alu_out,
  output logic [4:0]  WB_rd,
  output logic        MEM_fault
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Timeout fires on the 255th REQ cycle without ack (counter then reads 255).
  localparam logic [7:0] CNT_LAST = 8'd254;

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [7:0]  r_cnt;
  logic [31:0] r_hold;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic        r_fault;
  logic [1:0]  r_wb_ctlwb;
  logic [31:0] r_wb_read_data;
  logic [31:0] r_wb_alu_out;
  logic [4:0]  r_wb_rd;

  logic w_memop;
  logic w_misal;
  logic w_start;
  logic w_in_req;
  logic w_ack;
  logic w_timeout;
  logic w_stall;

  assign w_memop   = MEM_ctlm[1] | MEM_ctlm[0];
  assign w_misal   = w_memop & (MEM_alu_out[1:0] != 2'b00);
  assign w_start   = (r_state == S_IDLE) & w_memop & ~w_misal;
  assign w_in_req  = (r_state == S_REQ);
  // Ack takes priority over timeout when both land in the same cycle.
  assign w_ack     = w_in_req & dmem_ack;
  assign w_timeout = w_in_req & ~dmem_ack & (r_cnt == CNT_LAST);
  assign w_stall   = w_in_req | w_start;

  // Next-state selection for the IDLE -> REQ -> DONE access sequence.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next = S_REQ;
        else         w_next = S_IDLE;
      end
      S_REQ: begin
        if (w_ack || w_timeout) w_next = S_DONE;
        else                    w_next = S_REQ;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Access state: FSM, wait counter, latched request fields and read-data hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_hold  <= 32'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_addr  <= MEM_alu_out;
        r_wdata <= MEM_rd2;
        r_we    <= MEM_ctlm[0];
        r_cnt   <= 8'd0;
      end else if (w_ack) begin
        r_hold  <= r_we ? 32'd0 : dmem_rdata;
      end else if (w_in_req) begin
        r_cnt   <= r_cnt + 8'd1;
        if (w_timeout) r_hold <= 32'd0;
      end
    end
  end

  // Sticky fault: misaligned access or bus timeout, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault <= 1'b0;
    end else if (w_timeout || (w_misal && !w_stall)) begin
      r_fault <= 1'b1;
    end
  end

  // MEM/WB register: advances when not stalled, inserts a bubble otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_ctlwb     <= 2'b00;
      r_wb_read_data <= 32'd0;
      r_wb_alu_out   <= 32'd0;
      r_wb_rd        <= 5'd0;
    end else if (w_stall) begin
      r_wb_ctlwb     <= 2'b00;
    end else begin
      // A misaligned op must not write the register file.
      r_wb_ctlwb     <= w_misal ? {1'b0, MEM_ctlwb[0]} : MEM_ctlwb;
      r_wb_read_data <= (r_state == S_DONE) ? r_hold : dmem_rdata;
      r_wb_alu_out   <= MEM_alu_out;
      r_wb_rd        <= MEM_rd;
    end
  end

  assign dmem_req     = w_in_req;
  assign dmem_we      = w_in_req & r_we;
  assign dmem_addr    = r_addr;
  assign dmem_wdata   = r_wdata;
  assign MEM_stall    = w_stall;
  assign MEM_pcsrc    = MEM_ctlm[2] & MEM_alu_zero;
  assign MEM_target   = MEM_bpc;
  assign MEM_fault    = r_fault;
  assign WB_ctlwb     = r_wb_ctlwb;
  assign WB_read_data = r_wb_read_data;
  assign WB_alu_out   = r_wb_alu_out;
  assign WB_rd        = r_wb_rd;

endmodule
